// File: rtl/vend_sequencer_if.sv
// Bundles the signals between the coin/keypad front-end and the vend sequencer.
// The sequencer uses the slave modport; the front-end or driver side uses master.
interface vend_sequencer_if;
    logic       N;
    logic       D;
    logic       Q;
    logic       Sel;
    logic       Cancel;
    logic       VendReq;
    logic       VendDone;
    logic [1:0] CoinOut;
    logic       CoinAck;
    logic [6:0] Credit;
    logic       Reject;
    logic       Busy;

    modport master (
        output N, D, Q, Sel, Cancel, VendDone, CoinAck,
        input  VendReq, CoinOut, Credit, Reject, Busy
    );

    modport slave (
        input  N, D, Q, Sel, Cancel, VendDone, CoinAck,
        output VendReq, CoinOut, Credit, Reject, Busy
    );
endinterface

// File: rtl/vend_sequencer.sv
// Coin credit accumulator with vend and greedy change sequencing.
// Optional macro MULTI_VEND_EN: credit left after a vend returns to CREDIT instead of being paid out.
module vend_sequencer #(
    parameter int COST       = 25,
    parameter int MAX_CREDIT = 95,
    parameter int TIMEOUT    = 1000
) (
    input  logic            Clk,
    input  logic            Rst,
    vend_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CREDIT = 2'd1;
    localparam logic [1:0] VEND   = 2'd2;
    localparam logic [1:0] CHANGE = 2'd3;

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    COST_W  = 8'(COST);
    localparam logic [7:0]    MAX_W   = 8'(MAX_CREDIT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [6:0]    credit;
    logic [TW-1:0] to_cnt;
    logic          n_q, d_q, q_q;
    logic          vend_req;
    logic          reject;

    logic          n_edge, d_edge, q_edge;
    logic          multi, single, open, fits, accept, coin_reject;
    logic [7:0]    coin_val, credit_sum, credit_after_vend;
    logic [1:0]    coin_out;
    logic [6:0]    change_val;

    // Coin edge decode and the accept/reject decision for this cycle.
    always_comb begin
        n_edge      = bus.N & ~n_q;
        d_edge      = bus.D & ~d_q;
        q_edge      = bus.Q & ~q_q;
        multi       = (n_edge & d_edge) | (n_edge & q_edge) | (d_edge & q_edge);
        single      = (n_edge | d_edge | q_edge) & ~multi;
        coin_val    = q_edge ? 8'd25 : (d_edge ? 8'd10 : (n_edge ? 8'd5 : 8'd0));
        credit_sum  = {1'b0, credit} + coin_val;
        fits        = credit_sum <= MAX_W;
        open        = (state == IDLE) || (state == CREDIT);
        accept      = single & open & fits;
        coin_reject = multi | (single & ~(open & fits));
        credit_after_vend = {1'b0, credit} - COST_W;
    end

    // Greedy change selection; only driven while paying out.
    always_comb begin
        coin_out   = 2'b00;
        change_val = 7'd0;
        if (state == CHANGE) begin
            if (credit >= 7'd25) begin
                coin_out   = 2'b11;
                change_val = 7'd25;
            end else if (credit >= 7'd10) begin
                coin_out   = 2'b10;
                change_val = 7'd10;
            end else if (credit >= 7'd5) begin
                coin_out   = 2'b01;
                change_val = 7'd5;
            end
        end
    end

    // Edge-detect history loads the live inputs during reset so held levels never count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            credit   <= 7'd0;
            to_cnt   <= '0;
            vend_req <= 1'b0;
            reject   <= 1'b0;
            n_q      <= bus.N;
            d_q      <= bus.D;
            q_q      <= bus.Q;
        end else begin
            n_q    <= bus.N;
            d_q    <= bus.D;
            q_q    <= bus.Q;
            reject <= coin_reject;
            to_cnt <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        credit <= credit_sum[6:0];
                        state  <= CREDIT;
                    end
                end
                CREDIT: begin
                    if (accept)
                        credit <= credit_sum[6:0];
                    if (bus.Cancel) begin
                        state <= CHANGE;
                    end else if (bus.Sel && ({1'b0, credit} >= COST_W)) begin
                        state    <= VEND;
                        vend_req <= 1'b1;
                    end else if (!accept && !bus.Sel) begin
                        if (to_cnt == TO_LAST)
                            state <= CHANGE;
                        else
                            to_cnt <= to_cnt + 1'b1;
                    end
                end
                VEND: begin
                    if (bus.VendDone) begin
                        vend_req <= 1'b0;
                        credit   <= credit_after_vend[6:0];
`ifdef MULTI_VEND_EN
                        state    <= (credit_after_vend == 8'd0) ? IDLE : CREDIT;
`else
                        state    <= (credit_after_vend == 8'd0) ? IDLE : CHANGE;
`endif
                    end
                end
                CHANGE: begin
                    if (credit == 7'd0) begin
                        state <= IDLE;
                    end else if (bus.CoinAck && (coin_out != 2'b00)) begin
                        credit <= credit - change_val;
                        if (credit == change_val)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.VendReq = vend_req;
    assign bus.CoinOut = coin_out;
    assign bus.Credit  = credit;
    assign bus.Reject  = reject;
    assign bus.Busy    = (state == VEND) || (state == CHANGE);
endmodule
